fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req_valid  : fetch request is being presented
//   imem_req_ready  : memory accepts the request this cycle
//   imem_addr       : fetch address, meaningful while imem_req_valid=1
//   imem_resp_valid : instruction data is being returned
//   imem_resp_data  : returned instruction word
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Single-outstanding instruction fetch stage. Issues one request at a time to
// instruction memory, captures the returned word together with its PC and
// PC+4, and offers it to decode with a valid/ready handshake. A redirect from
// branch resolution overrides everything else and restarts fetch at the
// word-aligned target; a response already in flight is then dropped.
//   clk, rst        : clock, asynchronous active-high reset
//   imem            : instruction-memory bus (master modport)
//   redirect_valid  : redirect request, redirect_pc carries the target
//   F_valid/F_ready : handshake towards the fetch/decode pipeline register
//   F_instr         : fetched instruction
//   F_pc_out        : PC of F_instr
//   F_pc_out4       : PC of F_instr plus 4
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          imem,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  F_valid,
  input  logic                  F_ready,
  output logic [DATA_WIDTH-1:0] F_instr,
  output logic [DATA_WIDTH-1:0] F_pc_out,
  output logic [DATA_WIDTH-1:0] F_pc_out4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic                  discard, discard_next;
  logic                  capture;
  logic                  handshake;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] redirect_target;

  assign redirect_target     = redirect_pc & ALIGN_MASK;
  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_addr      = pc;
  assign handshake           = imem.imem_req_valid && imem.imem_req_ready;
  // A redirect in HOLD must suppress the hand-off in the very same cycle.
  assign F_valid             = (state == HOLD) && !redirect_valid;
  assign transfer            = F_valid && F_ready;

  // Next-state logic. Redirect is tested first in every state so it wins over
  // handshakes, responses and transfers. The discard flag marks a request that
  // was accepted for a stale PC so its response is thrown away on arrival.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    capture      = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect_valid) pc_next = redirect_target;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (handshake) begin
            state_next   = WAIT;
            discard_next = 1'b1;
          end
        end else if (handshake) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (imem.imem_resp_valid) begin
            state_next   = REQ;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end else if (imem.imem_resp_valid) begin
          if (discard) begin
            state_next   = REQ;
            discard_next = 1'b0;
          end else begin
            state_next = HOLD;
            capture    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (transfer) begin
          pc_next    = pc + PC_STEP;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      F_instr   <= '0;
      F_pc_out  <= '0;
      F_pc_out4 <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
      if (capture) begin
        F_instr   <= imem.imem_resp_data;
        F_pc_out  <= pc;
        F_pc_out4 <= pc + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios followed by randomized traffic. The reference model sees
// the fetch unit as a program-order instruction stream: every hand-off must
// carry the next expected PC, the memory word stored at that PC and PC+4; a
// redirect restarts the stream at the aligned target. The memory model keeps
// at most one request in flight and returns a word derived from its address,
// so stale or stray data cannot masquerade as the right instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        F_valid;
  logic        F_ready;
  logic [31:0] F_instr;
  logic [31:0] F_pc_out;
  logic [31:0] F_pc_out4;

  fetch_unit_if #(.DATA_WIDTH(DW)) imem_bus ();

  fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .F_valid        (F_valid),
    .F_ready        (F_ready),
    .F_instr        (F_instr),
    .F_pc_out       (F_pc_out),
    .F_pc_out4      (F_pc_out4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model state and knobs
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          ready_pct;
  int          lat_min;
  int          lat_max;
  int          stray_pct;

  // stream model state
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic [31:0] prev_pc4;
  int          n_xfer;
  int          quiet;
  logic        hs;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the edge, sample 2 time units later.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic fr);
    logic deliver;
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    F_ready        = fr;
    deliver        = mem_pend && (mem_cnt == 0);
    if (deliver) begin
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = memf(mem_addr);
    end else if (!mem_pend && int'($urandom_range(99)) < stray_pct) begin
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = 32'hBAD0_0000 | ($urandom & 32'hFFFF);
    end else begin
      imem_bus.imem_resp_valid = 1'b0;
      imem_bus.imem_resp_data  = $urandom;
    end
    imem_bus.imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    #1;
    hs = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
    if (rst) begin
      mem_pend  = 1'b0;
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
      quiet     = 0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", 32'(F_valid), 32'(!rv));
        checkOutput("hold_instr", F_instr, prev_instr);
        checkOutput("hold_pc", F_pc_out, prev_pc);
        checkOutput("hold_pc4", F_pc_out4, prev_pc4);
      end
      if (rv) begin
        checkOutput("redirect_blocks_valid", 32'(F_valid), 32'd0);
        exp_pc = rpc & 32'hFFFF_FFFC;
        quiet  = 0;
      end else if (F_valid && F_ready) begin
        checkOutput("xfer_pc", F_pc_out, exp_pc);
        checkOutput("xfer_instr", F_instr, memf(exp_pc));
        checkOutput("xfer_pc4", F_pc_out4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
        quiet = 0;
      end else begin
        quiet++;
      end
      prev_hold  = F_valid && !F_ready;
      prev_instr = F_instr;
      prev_pc    = F_pc_out;
      prev_pc4   = F_pc_out4;
      if (hs) checkOutput("one_outstanding", 32'(mem_pend), 32'd0);
      if (deliver) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (hs) begin
        mem_pend = 1'b1;
        mem_addr = imem_bus.imem_addr;
        mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end
    end
  endtask

  // Step until a request is accepted; reports how often F_valid was seen.
  task automatic waitReq(input string tag, input logic fr, output logic [31:0] addr,
                         output int vcount);
    int n = 0;
    vcount = 0;
    do begin
      applyStimulus(1'b0, 32'd0, fr);
      if (F_valid) vcount++;
      n++;
    end while (!hs && n < 40);
    checkOutput({tag, "_req_seen"}, 32'(hs), 32'd1);
    addr = imem_bus.imem_addr;
  endtask

  task automatic waitValid(input string tag, input logic fr);
    int n = 0;
    do begin
      applyStimulus(1'b0, 32'd0, fr);
      n++;
    end while (!F_valid && n < 40);
    checkOutput({tag, "_valid_seen"}, 32'(F_valid), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_F_valid"}, 32'(F_valid), 32'd0);
    checkOutput({tag, "_req_valid"}, 32'(imem_bus.imem_req_valid), 32'd0);
    checkOutput({tag, "_F_instr"}, F_instr, 32'd0);
    checkOutput({tag, "_F_pc_out"}, F_pc_out, 32'd0);
    checkOutput({tag, "_F_pc_out4"}, F_pc_out4, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          vc;
    logic        rv;
    logic [31:0] rpc;
    logic        fr;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    F_ready = 1'b0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data = 32'd0;
    mem_pend = 1'b0;
    mem_addr = 32'd0;
    mem_cnt = 0;
    ready_pct = 100;
    lat_min = 0;
    lat_max = 0;
    stray_pct = 0;
    exp_pc = RESET_PC;
    prev_hold = 1'b0;
    prev_instr = 32'd0;
    prev_pc = 32'd0;
    prev_pc4 = 32'd0;
    n_xfer = 0;
    quiet = 0;
    hs = 1'b0;

    // reset state
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkResetOutputs("reset");
    rst = 1'b0;
    #1;
    checkOutput("idle_quiet", 32'(imem_bus.imem_req_valid), 32'd0);

    // first fetch at RESET_PC with one-cycle memory latency
    waitReq("t1", 1'b1, a, vc);
    checkOutput("t1_addr", a, RESET_PC);
    waitValid("t1", 1'b1);
    checkOutput("t1_instr", F_instr, 32'h0050_0093);
    checkOutput("t1_pc", F_pc_out, 32'h0);
    checkOutput("t1_pc4", F_pc_out4, 32'h4);
    waitReq("t1b", 1'b1, a, vc);
    checkOutput("t1_next_addr", a, 32'h4);

    // decode stalls for five cycles while an instruction is held
    waitValid("t2", 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t2_stall_valid", 32'(F_valid), 32'd1);
      checkOutput("t2_stall_instr", F_instr, memf(32'h4));
      checkOutput("t2_stall_pc", F_pc_out, 32'h4);
      checkOutput("t2_stall_noreq", 32'(imem_bus.imem_req_valid), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    lat_min = 3;
    lat_max = 3;
    waitReq("t2", 1'b1, a, vc);
    checkOutput("t2_next_addr", a, 32'h8);

    // redirect while waiting; the late response must be dropped
    applyStimulus(1'b1, 32'h0000_0100, 1'b1);
    waitReq("t3", 1'b1, a, vc);
    checkOutput("t3_no_valid", 32'(vc), 32'd0);
    checkOutput("t3_addr", a, 32'h100);
    lat_min = 0;
    lat_max = 0;

    // redirect in HOLD coincident with F_ready blocks the hand-off
    waitValid("t4", 1'b0);
    applyStimulus(1'b1, 32'h0000_0203, 1'b1);
    checkOutput("t4_valid_low", 32'(F_valid), 32'd0);
    waitReq("t4", 1'b1, a, vc);
    checkOutput("t4_addr", a, 32'h200);

    // redirect with coincident response, then PC wrap at the top of memory
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    waitReq("t5", 1'b1, a, vc);
    checkOutput("t5_addr", a, 32'hFFFF_FFFC);
    waitValid("t5", 1'b1);
    checkOutput("t5_pc", F_pc_out, 32'hFFFF_FFFC);
    checkOutput("t5_pc4", F_pc_out4, 32'h0);
    lat_min = 3;
    lat_max = 3;
    waitReq("t5b", 1'b1, a, vc);
    checkOutput("t5_wrap_addr", a, 32'h0);

    // reset while a response is outstanding, stray response afterwards
    applyStimulus(1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    applyStimulus(1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_data = 32'hBAD0_1234;
    #1;
    checkOutput("t6_idle_noreq", 32'(imem_bus.imem_req_valid), 32'd0);
    checkOutput("t6_idle_novalid", 32'(F_valid), 32'd0);
    stray_pct = 100;
    waitReq("t6", 1'b1, a, vc);
    checkOutput("t6_addr", a, RESET_PC);
    checkOutput("t6_no_valid", 32'(vc), 32'd0);
    stray_pct = 0;
    lat_min = 1;
    lat_max = 1;
    waitValid("t6", 1'b0);
    checkOutput("t6_instr", F_instr, memf(RESET_PC));

    // randomized traffic
    ready_pct = 70;
    lat_min = 0;
    lat_max = 3;
    stray_pct = 15;
    for (int i = 0; i < 1500; i++) begin
      rv = (int'($urandom_range(99)) < 6);
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else rpc = $urandom;
      fr = (int'($urandom_range(99)) < 60);
      applyStimulus(rv, rpc, fr);
      if (quiet > 100) begin
        checkOutput("liveness", 32'(quiet), 32'd100);
        break;
      end
      if ($urandom_range(999) < 3) begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        rst = 1'b0;
      end
    end
    checkOutput("progress", 32'(n_xfer >= 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
